rr_merge_4: RTL and testbench

4-to-1 round-robin merger with packet locking: the collecting counterpart of the 1-to-4 distributor. Accepts beats from four valid/ready source channels and forwards them, one per cycle, onto a single registered valid/ready output tagged with the source index. Once a channel wins, the grant is held until that channel's beat with `last` set has been taken. Sits at the convergence point where four per-lane streams rejoin one shared datapath.

---
 rtl/rr_merge_4.sv | 116 +++++++++++
 tb/tb_rr_merge_4.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_merge_4.sv
// Four-channel round-robin merger with per-packet grant locking and one
// registered valid/ready output stage tagged with the source channel index.
module rr_merge_4 #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [3:0]       i_valid,
   output logic [3:0]       o_ready,
   input  logic [3:0]       i_last,
   input  logic [WIDTH-1:0] i_data0,
   input  logic [WIDTH-1:0] i_data1,
   input  logic [WIDTH-1:0] i_data2,
   input  logic [WIDTH-1:0] i_data3,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_last,
   output logic [1:0]       o_sel
);

   // state | meaning
   // IDLE  | arbitrate among all valid channels starting at ptr
   // LOCK  | mid-packet; only lock_ch may transfer until its last beat
   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       lock_ch;

   logic             load_en;
   logic [1:0]       grant;
   logic             grant_vld;
   logic [1:0]       cand;
   logic             accept;
   logic [WIDTH-1:0] grant_data;

   assign load_en = !o_valid || i_ready;

   // Scan from the farthest candidate down so the one nearest ptr wins.
   always_comb begin
      grant     = 2'd0;
      grant_vld = 1'b0;
      cand      = 2'd0;
      if (state == LOCK) begin
         grant     = lock_ch;
         grant_vld = 1'b1;
      end else begin
         for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (i_valid[cand]) begin
               grant     = cand;
               grant_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_ready = 4'b0000;
      if (i_rst_n && grant_vld && load_en) begin
         o_ready = 4'b0001 << grant;
      end
   end

   assign accept = |(i_valid & o_ready);

   always_comb begin
      unique case (grant)
         2'd0:    grant_data = i_data0;
         2'd1:    grant_data = i_data1;
         2'd2:    grant_data = i_data2;
         default: grant_data = i_data3;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         lock_ch <= 2'd0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
         o_sel   <= 2'd0;
      end else if (load_en) begin
         if (accept) begin
            o_valid <= 1'b1;
            o_data  <= grant_data;
            o_last  <= i_last[grant];
            o_sel   <= grant;
            ptr     <= grant + 2'd1;
            unique case (state)
               IDLE: begin
                  if (!i_last[grant]) begin
                     state   <= LOCK;
                     lock_ch <= grant;
                  end
               end
               LOCK: begin
                  if (i_last[grant]) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end else begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_merge_4.sv
// Directed and random-backpressure bench for rr_merge_4: arbitration order,
// packet locking, stall hold and a loss/duplication scoreboard.
module tb_rr_merge_4;

   localparam int WIDTH = 8;

   logic             i_clk;
   logic             i_rst_n;
   logic [3:0]       i_valid;
   logic [3:0]       o_ready;
   logic [3:0]       i_last;
   logic [WIDTH-1:0] i_data0, i_data1, i_data2, i_data3;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_data;
   logic             o_last;
   logic [1:0]       o_sel;

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] sb_q[$];

   rr_merge_4 #(.WIDTH(WIDTH)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_last  (i_last),
      .i_data0 (i_data0),
      .i_data1 (i_data1),
      .i_data2 (i_data2),
      .i_data3 (i_data3),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_last  (o_last),
      .o_sel   (o_sel)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a falling edge: apply inputs, check o_ready, cross one rising
   // edge, then check the registered output.
   task automatic vec(input logic [3:0] v, input logic [3:0] l, input logic [3:0] exp_rdy,
                      input logic exp_vld, input logic [1:0] exp_sel,
                      input logic [7:0] exp_data, input logic exp_last);
      i_valid = v;
      i_last  = l;
      #1;
      check("o_ready", 32'(o_ready), 32'(exp_rdy));
      @(posedge i_clk);
      @(negedge i_clk);
      check("o_valid", 32'(o_valid), 32'(exp_vld));
      if (exp_vld) begin
         check("o_sel", 32'(o_sel), 32'(exp_sel));
         check("o_data", 32'(o_data), 32'(exp_data));
         check("o_last", 32'(o_last), 32'(exp_last));
      end
   endtask

   task automatic rotation();
      vec(4'hF, 4'hF, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1);
      vec(4'hF, 4'hF, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1);
      vec(4'hF, 4'hF, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1);
      vec(4'hF, 4'hF, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1);
      vec(4'hF, 4'hF, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1);
   endtask

   task automatic check_reset_outputs();
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_data", 32'(o_data), 32'd0);
      check("rst_o_last", 32'(o_last), 32'd0);
      check("rst_o_sel", 32'(o_sel), 32'd0);
      check("rst_o_ready", 32'(o_ready), 32'd0);
   endtask

   initial begin
      logic [1:0]  ch;
      logic [10:0] exp_beat;
      logic        drain;

      i_rst_n = 1'b0;
      i_valid = 4'hF;
      i_last  = 4'hF;
      i_ready = 1'b1;
      i_data0 = 8'hA0;
      i_data1 = 8'hA1;
      i_data2 = 8'hA2;
      i_data3 = 8'hA3;
      @(negedge i_clk);
      @(negedge i_clk);
      check_reset_outputs();
      i_rst_n = 1'b1;

      rotation();

      // Lock channel 1 mid-packet, then reset asynchronously.
      vec(4'hF, 4'h0, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b0);
      i_rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge i_clk);
      check_reset_outputs();
      i_valid = 4'hF;
      i_last  = 4'hF;
      i_rst_n = 1'b1;
      rotation();

      // Fairness with gaps: ptr=1 here.
      vec(4'b1010, 4'hF, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1);
      vec(4'b1010, 4'hF, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1);
      vec(4'b1010, 4'hF, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1);
      vec(4'b1010, 4'hF, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1);

      // ptr=0: grant channel 1 alone to move ptr to 2, then a 3-beat packet on 2.
      vec(4'b0010, 4'hF, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1);
      vec(4'hF, 4'b1011, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b0);
      vec(4'hF, 4'b1011, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b0);
      vec(4'hF, 4'hF,    4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1);
      vec(4'hF, 4'hF,    4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1);
      vec(4'hF, 4'hF,    4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1);
      vec(4'hF, 4'hF,    4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1);

      // ptr=2: lock channel 0, let it go idle for two cycles while channel 1 waits.
      vec(4'b0001, 4'b1110, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b0);
      vec(4'b0010, 4'hF,    4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
      vec(4'b0010, 4'hF,    4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
      vec(4'b0011, 4'hF,    4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1);

      // Backpressure: held beat is channel 0 / A0 / last, ptr=1.
      i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         i_data0 = 8'h55 + 8'(i);
         vec(4'hF, 4'hF, 4'b0000, 1'b1, 2'd0, 8'hA0, 1'b1);
      end
      i_data0 = 8'hA0;
      i_ready = 1'b1;
      vec(4'hF, 4'hF, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1);
      vec(4'h0, 4'hF, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);

      // Random traffic and backpressure against a transfer scoreboard.
      for (int cyc = 0; cyc < 1010; cyc++) begin
         drain = (cyc >= 1000);
         if (drain) begin
            i_valid = 4'h0;
            i_ready = 1'b1;
         end else begin
            i_valid = 4'($urandom_range(0, 15));
            i_last  = 4'($urandom_range(0, 15));
            i_ready = ($urandom_range(0, 3) != 0);
            i_data0 = 8'($urandom);
            i_data1 = 8'($urandom);
            i_data2 = 8'($urandom);
            i_data3 = 8'($urandom);
         end
         #1;
         check("ready_onehot", 32'($onehot0(o_ready)), 32'd1);
         if (o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_extra_beat", {21'd0, o_sel, o_last, o_data}, 32'h7FF);
            end else begin
               exp_beat = sb_q.pop_front();
               check("sb_beat", {21'd0, o_sel, o_last, o_data}, {21'd0, exp_beat});
            end
         end
         if (|(i_valid & o_ready)) begin
            ch = 2'd0;
            for (int k = 0; k < 4; k++) begin
               if (o_ready[k]) ch = 2'(k);
            end
            unique case (ch)
               2'd0:    sb_q.push_back({ch, i_last[0], i_data0});
               2'd1:    sb_q.push_back({ch, i_last[1], i_data1});
               2'd2:    sb_q.push_back({ch, i_last[2], i_data2});
               default: sb_q.push_back({ch, i_last[3], i_data3});
            endcase
         end
         @(negedge i_clk);
      end
      check("sb_leftover", 32'(sb_q.size()), 32'd0);
      check("drain_o_valid", 32'(o_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
